// File: rtl/uart_tx_ctrl_if.sv
// UART transmit sequencer handshake bundle.
// Host side drives tick/request/data; sequencer drives the line and status.
interface uart_tx_ctrl_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output s_tick,
        output tx_start,
        output din,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  s_tick,
        input  tx_start,
        input  din,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DBIT data bits LSB-first, stop period.
// Bit timing comes from an external oversampling tick.
module uart_tx_ctrl #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] OS_LAST = 8'(OS - 1);
    localparam logic [7:0] SB_LAST = 8'(SB_TICK - 1);
    localparam logic [3:0] N_LAST  = 4'(DBIT - 1);

    state_t          state_q, state_d;
    logic [7:0]      s_cnt_q, s_cnt_d;
    logic [3:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done;

    // State, counters, shift register and line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; the line level follows the next state so tx
    // changes on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    b_d     = bus.din;
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 8'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 4'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 8'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = (state_q != IDLE);
    assign bus.tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (DBIT=8, OS=16, SB_TICK=16).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;

    uart_tx_ctrl_if #(.DBIT(8)) bus ();

    uart_tx_ctrl #(
        .DBIT    (8),
        .OS      (16),
        .SB_TICK (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slot 0 is the start bit, slots 1..8 data LSB-first, slot 9 stop.
    function automatic logic exp_tx(input logic [7:0] d, input int c,
                                    input int p);
        int slot;
        slot = c / (16 * p);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic idle_watch(input string tag, input int n);
        int dn, bz, hi;
        dn = 0; bz = 0; hi = 0;
        repeat (n) begin
            bus.tx_start = 1'b0;
            bus.s_tick   = 1'b1;
            #1;
            if (bus.tx_done_tick === 1'b1) dn++;
            if (bus.tx_busy !== 1'b0) bz++;
            if (bus.tx === 1'b1) hi++;
            @(negedge clk);
        end
        check({tag, "_done"}, dn, 0);
        check({tag, "_busy"}, bz, 0);
        check({tag, "_txhi"}, hi, n);
    endtask

    // One frame; tick arrives on the last cycle of every p-cycle group.
    task automatic run_frame(input string tag, input logic [7:0] d,
                             input int p, input bit chain,
                             input int mid_at, input logic [7:0] mid_din,
                             input bit hold, input logic [7:0] nxt);
        int last, bad, bbad, dn, dpos;
        last = 160 * p;
        bad = 0; bbad = 0; dn = 0; dpos = -1;
        if (!chain) begin
            bus.din      = d;
            bus.tx_start = 1'b1;
            bus.s_tick   = 1'b0;
            @(negedge clk);
        end
        for (int c = 0; c <= last; c++) begin
            if (c < last) begin
                bus.tx_start = hold || (c == mid_at);
                if (mid_at >= 0 && c >= mid_at) bus.din = mid_din;
                bus.s_tick = ((c % p) == p - 1);
            end else begin
                bus.tx_start = hold;
                bus.din      = nxt;
                bus.s_tick   = 1'b0;
            end
            #1;
            if (c < last) begin
                if (bus.tx !== exp_tx(d, c, p)) bad++;
                if (bus.tx_busy !== 1'b1) bbad++;
            end else begin
                check({tag, "_gap_tx"}, bus.tx, 1);
                check({tag, "_gap_busy"}, bus.tx_busy, 0);
            end
            if (bus.tx_done_tick === 1'b1) begin
                dn++;
                if (dpos < 0) dpos = c;
            end
            @(negedge clk);
        end
        if (!hold) bus.tx_start = 1'b0;
        check({tag, "_tx_bad_cycles"}, bad, 0);
        check({tag, "_busy_bad_cycles"}, bbad, 0);
        check({tag, "_done_count"}, dn, 1);
        check({tag, "_done_cycle"}, dpos, last - 1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.s_tick   = 1'b0;
        bus.din      = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_done", bus.tx_done_tick, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Test 1: reset in idle with request and ticks present.
        reset        = 1'b1;
        bus.tx_start = 1'b1;
        bus.s_tick   = 1'b1;
        bus.din      = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_tx", bus.tx, 1);
            check("t1_busy", bus.tx_busy, 0);
            check("t1_done", bus.tx_done_tick, 0);
        end
        reset        = 1'b0;
        bus.tx_start = 1'b0;
        idle_watch("t1_after", 5);

        // Test 2: basic frame, tick every cycle.
        run_frame("t2", 8'hA5, 1, 1'b0, -1, 8'h00, 1'b0, 8'h00);
        idle_watch("t2_after", 5);

        // Test 3: request during DATA is ignored.
        run_frame("t3", 8'hA5, 1, 1'b0, 40, 8'hFF, 1'b0, 8'h00);
        idle_watch("t3_after", 40);

        // Request on the done cycle is ignored as well.
        run_frame("t3d", 8'hA5, 1, 1'b0, 159, 8'hFF, 1'b0, 8'h00);
        idle_watch("t3d_after", 40);

        // Test 4: tick every 4th cycle, all-zero data.
        run_frame("t4", 8'h00, 4, 1'b0, -1, 8'h00, 1'b0, 8'h00);
        idle_watch("t4_after", 5);

        // Test 5: reset in DATA bit 3 (0x96 bit 3 = 0).
        bus.din      = 8'h96;
        bus.tx_start = 1'b1;
        bus.s_tick   = 1'b0;
        @(negedge clk);
        bus.tx_start = 1'b0;
        for (int c = 0; c < 69; c++) begin
            bus.s_tick = 1'b1;
            @(negedge clk);
        end
        bus.s_tick = 1'b1;
        #1;
        check("t5_pre_tx", bus.tx, 0);
        check("t5_pre_busy", bus.tx_busy, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_done", bus.tx_done_tick, 0);
        @(negedge clk);
        check("t5_tx", bus.tx, 1);
        check("t5_busy", bus.tx_busy, 0);
        check("t5_done", bus.tx_done_tick, 0);
        reset = 1'b0;
        idle_watch("t5_quiet", 200);
        run_frame("t5_clean", 8'h5A, 1, 1'b0, -1, 8'h00, 1'b0, 8'h00);
        idle_watch("t5_after", 5);

        // Test 6: tx_start held, two frames back-to-back.
        run_frame("t6a", 8'h3C, 1, 1'b0, -1, 8'h00, 1'b1, 8'hC3);
        run_frame("t6b", 8'hC3, 1, 1'b1, -1, 8'h00, 1'b0, 8'h00);
        idle_watch("t6_after", 20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
